// File: rtl/y86_pkg.sv
// y86_pkg: register IDs and register-file sizing shared by decode and write-back
package y86_pkg;
    localparam logic [3:0] RRSP      = 4'h4;
    localparam logic [3:0] RNONE     = 4'hF;
    localparam int         NREGS_DEF = 15;
endpackage

// File: rtl/reg_file_read_port.sv
// reg_read_port: one read port (ID decode plus optional write bypass)
//   src_i             read ID; RNONE or out-of-range reads return zero
//   regs_i            current register contents
//   wr_en_i, dst_*_i, val_*_i   this cycle's write ports, used only when BYPASS != 0
//   val_o             read data
module reg_read_port
    import y86_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int BYPASS = 0
) (
    input  logic [3:0]  src_i,
    input  logic [63:0] regs_i [NREGS],
    input  logic        wr_en_i,
    input  logic [3:0]  dst_e_i,
    input  logic [63:0] val_e_i,
    input  logic [3:0]  dst_m_i,
    input  logic [63:0] val_m_i,
    output logic [63:0] val_o
);
    logic hit_e, hit_m, none;
    always_comb begin
        none  = (src_i == RNONE) || (int'(src_i) >= NREGS);
        // M is checked first so a same-register E/M pair forwards M, matching the write priority
        hit_m = (BYPASS != 0) && wr_en_i && !none && (src_i == dst_m_i);
        hit_e = (BYPASS != 0) && wr_en_i && !none && (src_i == dst_e_i);
        val_o = none ? 64'h0 : hit_m ? val_m_i : hit_e ? val_e_i : regs_i[src_i];
    end
endmodule

// File: rtl/reg_file.sv
// reg_file: Y86 register file, two write ports (E, M), three read ports (A, B, debug)
//   clk, reset        single clock, synchronous active-high reset
//   wr_en             global write enable (low = stall)
//   dstE/valE, dstM/valM   write ports; ID 0xF = none; M wins on a same-register collision
//   srcA/valA, srcB/valB, dbg_id/dbg_val   combinational read ports
//   wr_cnt            count of distinct registers written, wraps mod 2^32
module reg_file
    import y86_pkg::*;
#(
    parameter int          NREGS   = NREGS_DEF,
    parameter logic [63:0] SP_INIT = 64'h0,
    parameter int          BYPASS  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  dstE,
    input  logic [63:0] valE,
    input  logic [3:0]  dstM,
    input  logic [63:0] valM,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    input  logic [3:0]  dbg_id,
    output logic [63:0] dbg_val,
    output logic [31:0] wr_cnt
);
    logic [63:0] regs_q [NREGS];
    logic [63:0] regs_d [NREGS];
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic        we_e, we_m;
    always_comb begin
        regs_d   = regs_q;
        we_e     = wr_en && (dstE != RNONE) && (int'(dstE) < NREGS);
        we_m     = wr_en && (dstM != RNONE) && (int'(dstM) < NREGS);
        if (we_e) regs_d[dstE] = valE;
        // M written after E so it overrides on a collision
        if (we_m) regs_d[dstM] = valM;
        wr_cnt_d = wr_cnt_q + 32'(we_e) + 32'(we_m && !(we_e && dstE == dstM));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= (i == int'(RRSP)) ? SP_INIT : 64'h0;
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end
    assign wr_cnt = wr_cnt_q;
    reg_read_port #(.NREGS(NREGS), .BYPASS(BYPASS)) u_rd_a (
        .src_i(srcA), .regs_i(regs_q), .wr_en_i(wr_en), .dst_e_i(dstE), .val_e_i(valE),
        .dst_m_i(dstM), .val_m_i(valM), .val_o(valA)
    );
    reg_read_port #(.NREGS(NREGS), .BYPASS(BYPASS)) u_rd_b (
        .src_i(srcB), .regs_i(regs_q), .wr_en_i(wr_en), .dst_e_i(dstE), .val_e_i(valE),
        .dst_m_i(dstM), .val_m_i(valM), .val_o(valB)
    );
    reg_read_port #(.NREGS(NREGS), .BYPASS(BYPASS)) u_rd_dbg (
        .src_i(dbg_id), .regs_i(regs_q), .wr_en_i(wr_en), .dst_e_i(dstE), .val_e_i(valE),
        .dst_m_i(dstM), .val_m_i(valM), .val_o(dbg_val)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file with BYPASS=0 and BYPASS=1 instances
module tb_reg_file;
    localparam logic [63:0] SP = 64'h200;
    logic        clk = 1'b0;
    logic        reset = 1'b0, wr_en = 1'b0;
    logic [3:0]  dstE = 4'hF, dstM = 4'hF, srcA = 4'hF, srcB = 4'hF, dbg_id = 4'hF;
    logic [63:0] valE = '0, valM = '0;
    logic [63:0] valA0, valB0, dbg0, valA1, valB1, dbg1;
    logic [31:0] cnt0, cnt1;
    always #5 clk = ~clk;
    reg_file #(.SP_INIT(SP), .BYPASS(0)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .dstE(dstE), .valE(valE), .dstM(dstM),
        .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valA0), .valB(valB0),
        .dbg_id(dbg_id), .dbg_val(dbg0), .wr_cnt(cnt0)
    );
    reg_file #(.SP_INIT(SP), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .dstE(dstE), .valE(valE), .dstM(dstM),
        .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valA1), .valB(valB1),
        .dbg_id(dbg_id), .dbg_val(dbg1), .wr_cnt(cnt1)
    );
    typedef struct {
        logic [63:0] a0, b0, d0, a1, b1, d1;
        logic [31:0] cnt;
    } exp_t;
    exp_t        sb_q[$];
    event        chk_ev;
    int          passed = 0, total = 0;
    logic [63:0] m_regs [15];
    logic [31:0] m_cnt;
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask
    // reference read: ID 0xF is zero; bypass forwards the active write, M before E
    function automatic logic [63:0] rd(input logic [3:0] id, input bit byp);
        if (id == 4'hF) return 64'h0;
        if (byp && wr_en && id == dstM) return valM;
        if (byp && wr_en && id == dstE) return valE;
        return m_regs[id];
    endfunction
    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 64'h0;
        m_regs[4] = SP;
        m_cnt = 32'h0;
    endtask
    task automatic model_edge();
        int n;
        if (reset) model_reset();
        else if (wr_en) begin
            n = 0;
            if (dstE != 4'hF) begin m_regs[dstE] = valE; n++; end
            if (dstM != 4'hF) begin m_regs[dstM] = valM; if (dstM != dstE) n++; end
            m_cnt = m_cnt + 32'(n);
        end
    endtask
    task automatic step(input logic r, input logic w, input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm,
                        input logic [3:0] sa, input logic [3:0] sbid, input logic [3:0] di);
        exp_t e;
        @(negedge clk);
        reset = r; wr_en = w; dstE = de; valE = ve; dstM = dm; valM = vm;
        srcA = sa; srcB = sbid; dbg_id = di;
        #1;
        e.a0 = rd(sa, 0); e.b0 = rd(sbid, 0); e.d0 = rd(di, 0);
        e.a1 = rd(sa, 1); e.b1 = rd(sbid, 1); e.d1 = rd(di, 1);
        e.cnt = m_cnt;
        sb_q.push_back(e);
        ->chk_ev;
        @(posedge clk);
        model_edge();
    endtask
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL scoreboard: got empty queue expected an entry");
            end else begin
                e = sb_q.pop_front();
                cmp("valA_b0", valA0, e.a0);
                cmp("valB_b0", valB0, e.b0);
                cmp("dbg_b0", dbg0, e.d0);
                cmp("valA_b1", valA1, e.a1);
                cmp("valB_b1", valB1, e.b1);
                cmp("dbg_b1", dbg1, e.d1);
                cmp("wr_cnt_b0", {32'h0, cnt0}, {32'h0, e.cnt});
                cmp("wr_cnt_b1", {32'h0, cnt1}, {32'h0, e.cnt});
            end
        end
    end
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [3:0] de, dm;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        step(0, 0, 4'hF, 0, 4'hF, 0, 4'h4, 4'h0, 4'h4);
        step(0, 0, 4'hF, 0, 4'hF, 0, 4'hF, 4'hF, 4'h0);
        step(0, 1, 4'h2, 64'hA, 4'h3, 64'hB, 4'hF, 4'hF, 4'h2);
        step(0, 0, 4'hF, 0, 4'hF, 0, 4'h2, 4'h3, 4'h4);
        step(0, 1, 4'h4, 64'h1F8, 4'h4, 64'h55, 4'h4, 4'h2, 4'h4);
        step(0, 0, 4'hF, 0, 4'hF, 0, 4'h4, 4'h3, 4'h4);
        step(0, 0, 4'h1, 64'h7, 4'hF, 0, 4'h1, 4'hF, 4'h1);
        step(0, 1, 4'hF, 64'h9, 4'hF, 64'h9, 4'h1, 4'hF, 4'h1);
        step(0, 0, 4'hF, 0, 4'hF, 0, 4'hF, 4'h1, 4'h4);
        step(0, 1, 4'h5, 64'h10, 4'hF, 0, 4'h5, 4'hF, 4'h5);
        step(0, 1, 4'h5, 64'h20, 4'hF, 0, 4'h5, 4'h5, 4'h5);
        step(0, 0, 4'hF, 0, 4'hF, 0, 4'h5, 4'h5, 4'h5);
        step(1, 1, 4'h6, 64'hFF, 4'hF, 0, 4'h6, 4'h4, 4'h6);
        step(0, 0, 4'hF, 0, 4'hF, 0, 4'h6, 4'h4, 4'h6);
        @(negedge clk);
        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        force dut_b.wr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt_q;
        release dut_b.wr_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        step(0, 1, 4'h0, 64'h1, 4'hF, 0, 4'h0, 4'hF, 4'h0);
        step(0, 0, 4'hF, 0, 4'hF, 0, 4'h0, 4'hF, 4'h0);
        for (int i = 0; i < 400; i++) begin
            de = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            dm = ($urandom_range(0, 3) == 0) ? 4'hF : ($urandom_range(0, 4) == 0) ? de : 4'($urandom_range(0, 14));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, de,
                 {$urandom, $urandom}, dm, {$urandom, $urandom},
                 4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 0) ? de : 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 0) ? dm : 4'($urandom_range(0, 15)));
        end
        #20;
        if (sb_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
